voice_allocator: RTL

//  Polyphonic voice scheduler between key decode and the oscillator/mixer bank.

---
 rtl/synth_pkg.sv | 22 ++
 rtl/voice_age_tracker.sv | 31 +++
 rtl/voice_allocator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and defaults for the synth voice path.
// Voice counts, note/phase typedefs, unity volume, allocator FSM states.
package synth_pkg;

  localparam int DEF_NUM_VOICES = 8;
  localparam int DEF_TOP_NOTE   = 31;
  localparam int DEF_AGE_W      = 8;

  typedef logic [7:0]  note_t;
  typedef logic [$clog2(DEF_NUM_VOICES)-1:0] voice_idx_t;
  typedef logic [31:0] phase_t;

  // Q11.20 unity gain
  localparam phase_t FULL_VOL = 32'h0010_0000;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters used to pick a steal victim.
// Ports: clk, reset, clr/clr_idx (zero one voice), bump (mask of +1), ages.
module voice_age_tracker
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = DEF_AGE_W,
  localparam int IW        = $clog2(NUM_VOICES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clr,
  input  logic [IW-1:0]                      clr_idx,
  input  logic [NUM_VOICES-1:0]              bump,
  output logic [NUM_VOICES-1:0][AGE_W-1:0]   ages
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ages <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (clr && clr_idx == IW'(i))
          ages[i] <= '0;
        else if (bump[i] && ages[i] != '1)
          ages[i] <= ages[i] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger, else lowest free, else steal oldest.
// Ports: clk, reset, ev_* handshake in, per-voice freq/volume/gate out, alloc info.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int TOP_NOTE   = DEF_TOP_NOTE,
  parameter int AGE_W      = DEF_AGE_W,
  localparam int IW        = $clog2(NUM_VOICES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [7:0]                      ev_note,
  input  logic [31:0]                     ev_freq,
  output logic [NUM_VOICES-1:0][31:0]     frequencies,
  output logic [NUM_VOICES-1:0][31:0]     voice_volumes,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [IW-1:0]                   alloc_voice,
  output logic                            alloc_stolen
);

  alloc_state_t state, nstate;

  logic armed;
  logic [IW-1:0] scan_idx;
  logic lat_on;
  note_t lat_note;
  phase_t lat_freq;

  logic hit_ok, free_ok, old_ok;
  logic [IW-1:0] hit_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;

  note_t [NUM_VOICES-1:0] notes;
  logic [NUM_VOICES-1:0][AGE_W-1:0] ages;

  logic legal, do_on, do_off, steal;
  logic [IW-1:0] pick_idx;
  logic [NUM_VOICES-1:0] pick_mask, bump;

  // Ready comes up one edge after reset release.
  assign ev_ready = armed && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= nstate;
      armed <= 1'b1;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (ev_valid && ev_ready) nstate = SCAN;
      SCAN:    if (scan_idx == IW'(NUM_VOICES - 1)) nstate = COMMIT;
      COMMIT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Scan comparator: one voice per cycle against stable voice state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx <= '0;
      lat_on   <= 1'b0;
      lat_note <= '0;
      lat_freq <= '0;
      hit_ok   <= 1'b0;
      free_ok  <= 1'b0;
      old_ok   <= 1'b0;
      hit_idx  <= '0;
      free_idx <= '0;
      old_idx  <= '0;
      old_age  <= '0;
    end else if (state == IDLE) begin
      if (ev_valid && ev_ready) begin
        lat_on   <= ev_on;
        lat_note <= ev_note;
        lat_freq <= ev_freq;
        scan_idx <= '0;
        hit_ok   <= 1'b0;
        free_ok  <= 1'b0;
        old_ok   <= 1'b0;
        old_age  <= '0;
      end
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + 1'b1;
      if (voice_gate[scan_idx] && notes[scan_idx] == lat_note && !hit_ok) begin
        hit_ok  <= 1'b1;
        hit_idx <= scan_idx;
      end
      if (!voice_gate[scan_idx] && !free_ok) begin
        free_ok  <= 1'b1;
        free_idx <= scan_idx;
      end
      // Strict compare keeps the lowest index on age ties.
      if (voice_gate[scan_idx] && (!old_ok || ages[scan_idx] > old_age)) begin
        old_ok  <= 1'b1;
        old_idx <= scan_idx;
        old_age <= ages[scan_idx];
      end
    end
  end

  assign legal     = int'(lat_note) <= TOP_NOTE;
  assign do_on     = (state == COMMIT) && lat_on && legal;
  assign do_off    = (state == COMMIT) && !lat_on && legal;
  assign steal     = !hit_ok && !free_ok;
  assign pick_idx  = hit_ok ? hit_idx : (free_ok ? free_idx : old_idx);
  assign pick_mask = NUM_VOICES'(1) << pick_idx;
  assign bump      = do_on ? (voice_gate & ~pick_mask) : '0;

  voice_age_tracker #(
    .NUM_VOICES(NUM_VOICES),
    .AGE_W     (AGE_W)
  ) u_age (
    .clk    (clk),
    .reset  (reset),
    .clr    (do_on),
    .clr_idx(pick_idx),
    .bump   (bump),
    .ages   (ages)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frequencies   <= '0;
      voice_volumes <= '0;
      voice_gate    <= '0;
      notes         <= '0;
      alloc_voice   <= '0;
      alloc_stolen  <= 1'b0;
    end else begin
      alloc_stolen <= 1'b0;
      if (do_on) begin
        voice_gate[pick_idx]    <= 1'b1;
        voice_volumes[pick_idx] <= FULL_VOL;
        frequencies[pick_idx]   <= lat_freq;
        notes[pick_idx]         <= lat_note;
        alloc_voice             <= pick_idx;
        alloc_stolen            <= steal;
      end
      if (do_off) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (voice_gate[i] && notes[i] == lat_note) begin
            voice_gate[i]    <= 1'b0;
            voice_volumes[i] <= '0;
          end
        end
      end
    end
  end

endmodule
